// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: instruction field positions,
// opcode/aluop encodings, the nop instruction and the multdiv FSM state type.
package pipe_pkg;

  localparam int OPCODE_LSB = 27;
  localparam int RD_LSB     = 22;
  localparam int RS_LSB     = 17;
  localparam int RT_LSB     = 12;
  localparam int ALUOP_LSB  = 2;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [31:0] NOP_IR  = 32'h0000_0000;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Registers an instruction reads, each with a flag saying whether it is really a source.
  typedef struct packed {
    logic       rs_vld;
    logic [4:0] rs;
    logic       rt_vld;
    logic [4:0] rt;
    logic       rd_vld;
    logic [4:0] rd;
  } src_regs_t;

  function automatic logic [4:0] ir_field(input logic [31:0] ir, input int lsb);
    return ir[lsb +: 5];
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Instruction/status inputs and latch-control outputs of the pipeline sequencer.
// The slave modport is the sequencer; the master modport is the datapath side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      fd_ir;
  logic [31:0]      dx_ir;
  logic             branch_taken;
  logic             md_ready;
  logic             md_exception;

  logic             pc_en;
  logic             fd_en;
  logic             dx_en;
  logic             fd_bubble;
  logic             dx_bubble;
  logic             xm_bubble;
  logic             md_mult;
  logic             md_div;
  logic             xm_exc;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output fd_ir, dx_ir, branch_taken, md_ready, md_exception,
    input  pc_en, fd_en, dx_en, fd_bubble, dx_bubble, xm_bubble,
           md_mult, md_div, xm_exc, md_busy, stall_cnt
  );

  modport slave (
    input  fd_ir, dx_ir, branch_taken, md_ready, md_exception,
    output pc_en, fd_en, dx_en, fd_bubble, dx_bubble, xm_bubble,
           md_mult, md_div, xm_exc, md_busy, stall_cnt
  );
endinterface

// File: rtl/ir_src_decode.sv
// Extracts the source registers of one instruction: rs for R-type/addi/lw/sw,
// rt for R-type, and rd for sw/bne/blt/jr (those read rd rather than write it).
module ir_src_decode
  import pipe_pkg::*;
(
  input  logic [31:0] ir,
  output src_regs_t   src
);

  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = ir_field(ir, OPCODE_LSB);
  assign unused_ir = ^ir[11:0];

  always_comb begin
    src.rs     = ir_field(ir, RS_LSB);
    src.rt     = ir_field(ir, RT_LSB);
    src.rd     = ir_field(ir, RD_LSB);
    src.rs_vld = (opcode inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW});
    src.rt_vld = (opcode == OP_RTYPE);
    src.rd_vld = (opcode inside {OP_SW, OP_BNE, OP_BLT, OP_JR});
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: multdiv occupancy FSM, branch flush, load-use stall and a
// saturating stall counter. Load-use detection is built only with PIPE_LOAD_USE_STALL_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               clr_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int              TO_W    = $clog2(MD_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT);

  md_state_e        state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [4:0] dx_op, dx_alu;
  logic       dx_is_mul, dx_is_div;
  src_regs_t  fd_src;
  logic       load_use;
  logic       unused_dx;

  logic md_stall, md_release, md_exc, mult_p, div_p;
  logic pc_en;

  assign dx_op     = ir_field(bus.dx_ir, OPCODE_LSB);
  assign dx_alu    = ir_field(bus.dx_ir, ALUOP_LSB);
  assign dx_is_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
  assign dx_is_div = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);

  ir_src_decode u_fd_decode (
    .ir  (bus.fd_ir),
    .src (fd_src)
  );

`ifdef PIPE_LOAD_USE_STALL_EN
  logic [4:0] dx_rd;
  assign dx_rd = ir_field(bus.dx_ir, RD_LSB);

  always_comb begin
    load_use = 1'b0;
    if (dx_op == OP_LW && dx_rd != 5'd0)
      load_use = (fd_src.rs_vld && fd_src.rs == dx_rd) ||
                 (fd_src.rt_vld && fd_src.rt == dx_rd) ||
                 (fd_src.rd_vld && fd_src.rd == dx_rd);
  end
  assign unused_dx = ^{bus.dx_ir[21:7], bus.dx_ir[1:0]};
`else
  // Software schedules a nop after every lw, so no interlock is needed.
  assign load_use  = 1'b0;
  assign unused_dx = ^{fd_src, bus.dx_ir[26:7], bus.dx_ir[1:0]};
`endif

  // NOTE: every variable of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    md_stall   = 1'b0;
    md_release = 1'b0;
    md_exc     = 1'b0;
    mult_p     = 1'b0;
    div_p      = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (dx_is_mul || dx_is_div) begin
          mult_p   = dx_is_mul;
          div_p    = dx_is_div;
          md_stall = 1'b1;
          to_cnt_d = '0;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (bus.md_ready) begin
          md_release = 1'b1;
          md_exc     = bus.md_exception;
          state_d    = MD_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          // Unit never answered: let the instruction retire flagged as an exception.
          md_release = 1'b1;
          md_exc     = 1'b1;
          state_d    = MD_IDLE;
        end else begin
          md_stall = 1'b1;
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Priority: reset, multdiv stall/release, branch flush, load-use, normal flow.
  always_comb begin
    pc_en         = 1'b1;
    bus.fd_en     = 1'b1;
    bus.dx_en     = 1'b1;
    bus.fd_bubble = 1'b0;
    bus.dx_bubble = 1'b0;
    bus.xm_bubble = 1'b0;
    bus.md_mult   = 1'b0;
    bus.md_div    = 1'b0;
    bus.xm_exc    = 1'b0;
    if (!clr_n) begin
      // Nothing issues while held in reset.
    end else if (md_stall) begin
      pc_en         = 1'b0;
      bus.fd_en     = 1'b0;
      bus.dx_en     = 1'b0;
      bus.xm_bubble = 1'b1;
      bus.md_mult   = mult_p;
      bus.md_div    = div_p;
    end else if (md_release) begin
      bus.xm_exc = md_exc;
    end else if (bus.branch_taken) begin
      bus.fd_bubble = 1'b1;
      bus.dx_bubble = 1'b1;
    end else if (load_use) begin
      pc_en         = 1'b0;
      bus.fd_en     = 1'b0;
      bus.dx_bubble = 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= MD_IDLE;
      to_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      if (!pc_en && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.md_busy   = (state_q == MD_BUSY);
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int MD_TIMEOUT = 40;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef PIPE_LOAD_USE_STALL_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  logic clk;
  logic clr_n;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] act, input int exp);
    vectors++;
    if (act !== CNT_W'(exp)) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic bit is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'b00000) && (ir[6:2] == 5'b00110 || ir[6:2] == 5'b00111);
  endfunction

  // Load-use rule written directly from the ISA's source-register table.
  function automatic bit lu_hit(input logic [31:0] fd, input logic [31:0] dx);
    logic [4:0] fop, drd;
    bit hit;
    fop = fd[31:27];
    drd = dx[26:22];
    hit = 1'b0;
    if (dx[31:27] != 5'b01000 || drd == 5'd0) return 1'b0;
    if ((fop == 5'd0 || fop == 5'd5 || fop == 5'd8 || fop == 5'd7) && fd[21:17] == drd) hit = 1'b1;
    if (fop == 5'd0 && fd[16:12] == drd) hit = 1'b1;
    if ((fop == 5'd7 || fop == 5'd2 || fop == 5'd6 || fop == 5'd4) && fd[26:22] == drd) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [4:0] rd, rs, rt;
    rd = 5'($urandom_range(0, 3));
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0:       return mk_ir(OP_RTYPE, rd, rs, rt, ALU_MUL);
      1:       return mk_ir(OP_RTYPE, rd, rs, rt, ALU_DIV);
      2:       return mk_ir(OP_RTYPE, rd, rs, rt, 5'd0);
      3, 4:    return mk_ir(OP_LW, rd, rs, rt, 5'd0);
      5:       return mk_ir(OP_SW, rd, rs, rt, 5'd0);
      6:       return mk_ir(OP_ADDI, rd, rs, rt, 5'd0);
      7:       return mk_ir(OP_BNE, rd, rs, rt, 5'd0);
      8:       return mk_ir(($urandom_range(0, 1) == 0) ? OP_BLT : OP_JR, rd, rs, rt, 5'd0);
      default: return $urandom();
    endcase
  endfunction

  // Behavioural model: busy flag, issue cycle number, and stall total.
  bit m_busy  = 1'b0;
  int m_issue = 0;
  int m_stall = 0;
  int cyc     = 0;

  always @(negedge clk) begin : compare
    bit e_pc, e_fd, e_dx, e_fb, e_db, e_xb, e_mul, e_div, e_exc;
    bit issue, release_now, hold;
    if (!clr_n) begin
      m_busy  = 1'b0;
      m_stall = 0;
    end
    e_pc = 1; e_fd = 1; e_dx = 1; e_fb = 0; e_db = 0; e_xb = 0;
    e_mul = 0; e_div = 0; e_exc = 0;
    issue = 0; release_now = 0; hold = 0;
    if (clr_n) begin
      if (!m_busy && is_md(bus.dx_ir)) begin
        issue = 1;
        hold  = 1;
        e_mul = (bus.dx_ir[6:2] == 5'b00110);
        e_div = !e_mul;
      end else if (m_busy && (bus.md_ready || (cyc - m_issue) > MD_TIMEOUT)) begin
        release_now = 1;
        e_exc = bus.md_ready ? bus.md_exception : 1'b1;
      end else if (m_busy) begin
        hold = 1;
      end else if (bus.branch_taken) begin
        e_fb = 1;
        e_db = 1;
      end else if (LU_EN && lu_hit(bus.fd_ir, bus.dx_ir)) begin
        e_pc = 0;
        e_fd = 0;
        e_db = 1;
      end
      if (hold) begin
        e_pc = 0; e_fd = 0; e_dx = 0; e_xb = 1;
      end
    end
    check_bit("pc_en",     bus.pc_en,     e_pc);
    check_bit("fd_en",     bus.fd_en,     e_fd);
    check_bit("dx_en",     bus.dx_en,     e_dx);
    check_bit("fd_bubble", bus.fd_bubble, e_fb);
    check_bit("dx_bubble", bus.dx_bubble, e_db);
    check_bit("xm_bubble", bus.xm_bubble, e_xb);
    check_bit("md_mult",   bus.md_mult,   e_mul);
    check_bit("md_div",    bus.md_div,    e_div);
    check_bit("xm_exc",    bus.xm_exc,    e_exc);
    check_bit("md_busy",   bus.md_busy,   m_busy);
    check_cnt("stall_cnt", bus.stall_cnt, m_stall);
    if (clr_n) begin
      if (issue) begin
        m_busy  = 1'b1;
        m_issue = cyc;
      end
      if (release_now) m_busy = 1'b0;
      if (!e_pc && m_stall < CNT_MAX) m_stall++;
    end
    cyc++;
  end

  task automatic drive(input logic [31:0] fd, input logic [31:0] dx,
                       input logic br, input logic rdy, input logic exc);
    bus.fd_ir        = fd;
    bus.dx_ir        = dx;
    bus.branch_taken = br;
    bus.md_ready     = rdy;
    bus.md_exception = exc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] add_r5, lw_r5, lw_r0, add_r0, mul_ir, div_ir;
  int          lu_cnt;
  int          rdy_pct;

  initial begin
    add_r5 = mk_ir(OP_RTYPE, 5'd3, 5'd5, 5'd2, 5'd0);
    lw_r5  = mk_ir(OP_LW,    5'd5, 5'd1, 5'd0, 5'd0);
    lw_r0  = mk_ir(OP_LW,    5'd0, 5'd1, 5'd0, 5'd0);
    add_r0 = mk_ir(OP_RTYPE, 5'd3, 5'd0, 5'd2, 5'd0);
    mul_ir = mk_ir(OP_RTYPE, 5'd4, 5'd1, 5'd2, ALU_MUL);
    div_ir = mk_ir(OP_RTYPE, 5'd4, 5'd1, 5'd2, ALU_DIV);
    lu_cnt = LU_EN ? 1 : 0;

    clr_n = 1'b0;
    drive(NOP_IR, NOP_IR, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 clr_n = 1'b1;

    // Ten benign cycles after reset.
    repeat (10) next_cycle();
    @(negedge clk);
    check_cnt("benign_stall_cnt", bus.stall_cnt, 0);
    check_bit("benign_pc_en", bus.pc_en, 1'b1);
    check_bit("benign_xm_bubble", bus.xm_bubble, 1'b0);

    // lw r5 followed by a reader of r5, then the bubble, then an r0 load.
    next_cycle();
    drive(add_r5, lw_r5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("lu_pc_en", bus.pc_en, !LU_EN);
    check_bit("lu_dx_bubble", bus.dx_bubble, LU_EN);
    check_bit("lu_dx_en", bus.dx_en, 1'b1);
    next_cycle();
    drive(add_r5, NOP_IR, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_cnt("lu_stall_cnt", bus.stall_cnt, lu_cnt);
    check_bit("lu_resume_pc_en", bus.pc_en, 1'b1);
    next_cycle();
    drive(add_r0, lw_r0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("lu_r0_pc_en", bus.pc_en, 1'b1);
    check_bit("lu_r0_dx_bubble", bus.dx_bubble, 1'b0);

    // mul with md_ready on the 33rd cycle after the start pulse.
    next_cycle();
    drive(NOP_IR, mul_ir, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("mul_pulse", bus.md_mult, 1'b1);
    check_bit("mul_pulse_pc_en", bus.pc_en, 1'b0);
    check_bit("mul_pulse_busy", bus.md_busy, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      next_cycle();
      bus.md_ready = (k == 33);
      @(negedge clk);
      if (k < 33) begin
        check_bit("mul_hold_pc_en", bus.pc_en, 1'b0);
        check_bit("mul_hold_no_pulse", bus.md_mult, 1'b0);
      end else begin
        check_bit("mul_release_pc_en", bus.pc_en, 1'b1);
        check_bit("mul_release_xm_bubble", bus.xm_bubble, 1'b0);
        check_bit("mul_release_busy", bus.md_busy, 1'b1);
      end
    end
    next_cycle();
    drive(NOP_IR, NOP_IR, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("mul_idle_busy", bus.md_busy, 1'b0);
    check_cnt("mul_stall_cnt", bus.stall_cnt, lu_cnt + 33);

    // div that never completes: forced release after MD_TIMEOUT busy cycles.
    next_cycle();
    drive(NOP_IR, div_ir, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("div_pulse", bus.md_div, 1'b1);
    for (int k = 1; k <= MD_TIMEOUT + 1; k++) begin
      next_cycle();
      @(negedge clk);
      if (k <= MD_TIMEOUT) begin
        check_bit("div_hold_pc_en", bus.pc_en, 1'b0);
      end else begin
        check_bit("div_timeout_pc_en", bus.pc_en, 1'b1);
        check_bit("div_timeout_xm_exc", bus.xm_exc, 1'b1);
        check_bit("div_timeout_xm_bubble", bus.xm_bubble, 1'b0);
      end
    end
    next_cycle();
    drive(NOP_IR, NOP_IR, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("div_idle_busy", bus.md_busy, 1'b0);
    check_cnt("div_stall_cnt", bus.stall_cnt, lu_cnt + 33 + MD_TIMEOUT + 1);

    // Branch flush beats a simultaneous load-use hazard.
    next_cycle();
    drive(add_r5, lw_r5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("br_fd_bubble", bus.fd_bubble, 1'b1);
    check_bit("br_dx_bubble", bus.dx_bubble, 1'b1);
    check_bit("br_pc_en", bus.pc_en, 1'b1);

    // Reset in the middle of a busy multiply.
    next_cycle();
    drive(NOP_IR, mul_ir, 1'b0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_bit("rst_pre_busy", bus.md_busy, 1'b1);
    @(posedge clk);
    #1 clr_n = 1'b0;
    #1;
    check_bit("rst_busy", bus.md_busy, 1'b0);
    check_bit("rst_no_pulse", bus.md_mult, 1'b0);
    check_cnt("rst_stall_cnt", bus.stall_cnt, 0);
    next_cycle();
    drive(NOP_IR, NOP_IR, 1'b0, 1'b0, 1'b0);
    clr_n = 1'b1;

    // Randomized traffic, checked by the compare process.
    rdy_pct = 8;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (i % 150 == 0) rdy_pct = ($urandom_range(0, 2) == 0) ? 0 : 8;
      bus.fd_ir        = rand_ir();
      bus.dx_ir        = rand_ir();
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      bus.md_ready     = ($urandom_range(0, 99) < rdy_pct);
      bus.md_exception = 1'($urandom_range(0, 1));
      clr_n            = ($urandom_range(0, 499) != 0);
    end
    next_cycle();
    clr_n = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
